// File: rtl/mux_rr_nto1.sv
// Registered N-to-1 multiplexer with built-in round-robin / fixed-priority
// arbitration and valid/ready handshakes on every input and on the output.
module mux_rr_nto1 #(
    parameter  int WIDTH   = 64,
    parameter  int NCH     = 4,
    parameter  int RR_MODE = 1,
    localparam int SW      = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SW-1:0]        out_src,
    input  logic                 out_ready
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SW-1:0]    r_out_src;
    logic [SW-1:0]    r_ptr;

    logic [NCH-1:0]   w_grant;
    logic [SW-1:0]    w_gidx;
    logic             w_load_en;
    logic             w_xfer;
    logic [WIDTH-1:0] w_sel_data;
    logic [SW-1:0]    w_ptr_next;

    // Grant search: first valid channel at or after the pointer, with wrap
    always_comb begin : p_grant
        int          v_sum;
        logic [SW-1:0] v_idx;
        logic        v_found;
        w_grant = {NCH{1'b0}};
        w_gidx  = {SW{1'b0}};
        v_found = 1'b0;
        v_sum   = 0;
        v_idx   = {SW{1'b0}};
        for (int k = 0; k < NCH; k++) begin
            if (RR_MODE != 0) begin
                v_sum = int'(r_ptr) + k;
            end else begin
                v_sum = k;
            end
            v_idx = SW'(v_sum % NCH);
            if (!v_found && in_valid[v_idx]) begin
                v_found        = 1'b1;
                w_grant[v_idx] = 1'b1;
                w_gidx         = v_idx;
            end else begin
                v_found = v_found;
            end
        end
    end

    // Handshake qualification and selected-channel data
    always_comb begin
        w_load_en  = ~r_out_valid | out_ready;
        w_sel_data = in_data[w_gidx*WIDTH +: WIDTH];
        if (rst_n) begin
            in_ready = w_grant & {NCH{w_load_en}};
        end else begin
            in_ready = {NCH{1'b0}};
        end
        w_xfer = |(in_valid & in_ready);
        if (w_gidx == SW'(NCH - 1)) begin
            w_ptr_next = {SW{1'b0}};
        end else begin
            w_ptr_next = w_gidx + SW'(1);
        end
    end

    // Output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= {WIDTH{1'b0}};
            r_out_src   <= {SW{1'b0}};
            r_ptr       <= {SW{1'b0}};
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_src   <= w_gidx;
            r_ptr       <= (RR_MODE != 0) ? w_ptr_next : {SW{1'b0}};
        end else if (out_ready) begin
            // Drained with nothing new: data and source keep their last value
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_mux_rr_nto1.sv
// Directed bench for mux_rr_nto1: one round-robin and one fixed-priority
// instance share the same stimulus.
module tb_mux_rr_nto1;

    localparam int WIDTH = 64;
    localparam int NCH   = 4;
    localparam int SW    = 2;

    logic                 clk;
    logic                 rst_n;
    logic [NCH-1:0]       in_valid;
    logic [NCH*WIDTH-1:0] in_data;
    logic                 out_ready;

    logic [NCH-1:0]       rr_in_ready;
    logic                 rr_out_valid;
    logic [WIDTH-1:0]     rr_out_data;
    logic [SW-1:0]        rr_out_src;

    logic [NCH-1:0]       fp_in_ready;
    logic                 fp_out_valid;
    logic [WIDTH-1:0]     fp_out_data;
    logic [SW-1:0]        fp_out_src;

    int n_checks;
    int n_pass;

    mux_rr_nto1 #(.WIDTH(WIDTH), .NCH(NCH), .RR_MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rr_in_ready), .out_valid(rr_out_valid), .out_data(rr_out_data),
        .out_src(rr_out_src), .out_ready(out_ready)
    );

    mux_rr_nto1 #(.WIDTH(WIDTH), .NCH(NCH), .RR_MODE(0)) u_fp (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(fp_in_ready), .out_valid(fp_out_valid), .out_data(fp_out_data),
        .out_src(fp_out_src), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are observed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_default_data();
        for (int i = 0; i < NCH; i++) begin
            in_data[i*WIDTH +: WIDTH] = 64'hA0 + 64'(i);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        set_default_data();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        set_default_data();
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (rr_in_ready !== 4'b0000 || fp_in_ready !== 4'b0000)
                $display("FAIL reset_in_ready cyc%0d: got rr=%b fp=%b want 0000", c, rr_in_ready, fp_in_ready);
            else n_pass++;
            step();
        end
        n_checks++;
        if (rr_out_valid !== 1'b0 || rr_out_data !== 64'h0 || rr_out_src !== 2'd0)
            $display("FAIL reset_outputs: got v=%b d=%h s=%0d want v=0 d=0 s=0", rr_out_valid, rr_out_data, rr_out_src);
        else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (rr_in_ready !== 4'b0001)
            $display("FAIL reset_first_grant: got %b want 0001", rr_in_ready);
        else n_pass++;
        step();
        n_checks++;
        if (rr_out_valid !== 1'b1 || rr_out_src !== 2'd0 || rr_out_data !== 64'hA0)
            $display("FAIL reset_first_word: got v=%b s=%0d d=%h want v=1 s=0 d=a0", rr_out_valid, rr_out_src, rr_out_data);
        else n_pass++;
    endtask

    task automatic test_rr_fairness();
        logic [3:0] exp_rdy;
        do_reset();
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_rdy = 4'b0001 << (k % 4);
            #1;
            n_checks++;
            if (rr_in_ready !== exp_rdy)
                $display("FAIL rr_ready k%0d: got %b want %b", k, rr_in_ready, exp_rdy);
            else n_pass++;
            step();
            n_checks++;
            if (rr_out_valid !== 1'b1 || rr_out_src !== SW'(k % 4) || rr_out_data !== 64'hA0 + 64'(k % 4))
                $display("FAIL rr_word k%0d: got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                         k, rr_out_valid, rr_out_src, rr_out_data, k % 4, 64'hA0 + 64'(k % 4));
            else n_pass++;
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        in_valid  = 4'b1010;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++;
            if (fp_in_ready !== 4'b0010)
                $display("FAIL fp_ready k%0d: got %b want 0010", k, fp_in_ready);
            else n_pass++;
            step();
            n_checks++;
            if (fp_out_valid !== 1'b1 || fp_out_src !== 2'd1 || fp_out_data !== 64'hA1)
                $display("FAIL fp_word k%0d: got v=%b s=%0d d=%h want v=1 s=1 d=a1", k, fp_out_valid, fp_out_src, fp_out_data);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_data[0 +: WIDTH] = 64'hDEAD_BEEF_0000_0001;
        in_valid  = 4'b0001;
        out_ready = 1'b0;
        step();
        n_checks++;
        if (rr_out_valid !== 1'b1 || rr_out_data !== 64'hDEAD_BEEF_0000_0001)
            $display("FAIL bp_load: got v=%b d=%h want v=1 d=deadbeef00000001", rr_out_valid, rr_out_data);
        else n_pass++;
        in_valid = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (rr_in_ready !== 4'b0000)
                $display("FAIL bp_ready c%0d: got %b want 0000", c, rr_in_ready);
            else n_pass++;
            step();
            n_checks++;
            if (rr_out_valid !== 1'b1 || rr_out_data !== 64'hDEAD_BEEF_0000_0001 || rr_out_src !== 2'd0)
                $display("FAIL bp_hold c%0d: got v=%b d=%h s=%0d want v=1 d=deadbeef00000001 s=0",
                         c, rr_out_valid, rr_out_data, rr_out_src);
            else n_pass++;
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (rr_in_ready !== 4'b0100)
            $display("FAIL bp_release_ready: got %b want 0100", rr_in_ready);
        else n_pass++;
        step();
        n_checks++;
        if (rr_out_valid !== 1'b1 || rr_out_src !== 2'd2 || rr_out_data !== 64'hA2)
            $display("FAIL bp_release_word: got v=%b s=%0d d=%h want v=1 s=2 d=a2", rr_out_valid, rr_out_src, rr_out_data);
        else n_pass++;
        set_default_data();
    endtask

    // Continues from test_backpressure, which leaves the pointer at 3.
    task automatic test_wrap_sparse();
        in_valid  = 4'b0001;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (rr_in_ready !== 4'b0001)
            $display("FAIL wrap_ready: got %b want 0001", rr_in_ready);
        else n_pass++;
        step();
        n_checks++;
        if (rr_out_valid !== 1'b1 || rr_out_src !== 2'd0 || rr_out_data !== 64'hA0)
            $display("FAIL wrap_word: got v=%b s=%0d d=%h want v=1 s=0 d=a0", rr_out_valid, rr_out_src, rr_out_data);
        else n_pass++;
        in_valid = 4'b0000;
        step();
        n_checks++;
        if (rr_out_valid !== 1'b0 || rr_out_data !== 64'hA0 || rr_out_src !== 2'd0)
            $display("FAIL drain_hold: got v=%b d=%h s=%0d want v=0 d=a0 s=0", rr_out_valid, rr_out_data, rr_out_src);
        else n_pass++;
        in_valid = 4'b1111;
        #1;
        n_checks++;
        if (rr_in_ready !== 4'b0010)
            $display("FAIL wrap_ptr: got %b want 0010", rr_in_ready);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        in_valid  = 4'b0001;
        out_ready = 1'b1;
        step();
        in_valid = 4'b0010;
        #1;
        n_checks++;
        if (rr_out_valid !== 1'b1 || rr_in_ready !== 4'b0010)
            $display("FAIL midrst_pre: got v=%b rdy=%b want v=1 rdy=0010", rr_out_valid, rr_in_ready);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rr_in_ready !== 4'b0000)
            $display("FAIL midrst_ready: got %b want 0000", rr_in_ready);
        else n_pass++;
        step();
        n_checks++;
        if (rr_out_valid !== 1'b0 || rr_out_data !== 64'h0 || rr_out_src !== 2'd0)
            $display("FAIL midrst_out: got v=%b d=%h s=%0d want v=0 d=0 s=0", rr_out_valid, rr_out_data, rr_out_src);
        else n_pass++;
        rst_n    = 1'b1;
        in_valid = 4'b1111;
        #1;
        n_checks++;
        if (rr_in_ready !== 4'b0001)
            $display("FAIL midrst_ptr: got %b want 0001", rr_in_ready);
        else n_pass++;
        step();
        n_checks++;
        if (rr_out_src !== 2'd0 || rr_out_data !== 64'hA0)
            $display("FAIL midrst_word: got s=%0d d=%h want s=0 d=a0", rr_out_src, rr_out_data);
        else n_pass++;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        in_data   = '0;
        #1;
        test_reset();
        test_rr_fairness();
        test_fixed_priority();
        test_backpressure();
        test_wrap_sparse();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
